// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: in-order instruction prefetch queue between a
// pipelined instruction memory and decode. Keeps up to DEPTH sequential
// fetches in flight and flushes on redirect, squashing stale responses.
// Optional feature macro: PREFETCH_BYPASS_EN (forwards a returning word
// straight to decode when the queue is empty).
module instr_prefetch_buffer #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4,
    input  logic            dec_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;

    logic [SW-1:0]   inflight;
    logic            ret;
    logic            keep;
    logic            bypass;
    logic            handshake;
    logic            push;
    logic            pop;

    // Issue credit, return classification and push/pop decisions.
    always_comb begin
        inflight  = {1'b0, count} + {1'b0, outstanding};
        imem_req  = !reset && !redirect && (inflight < SW'(DEPTH));
        imem_addr = fetch_pc;
        ret       = imem_rvalid && (outstanding != '0);
        keep      = ret && (discard == '0);
`ifdef PREFETCH_BYPASS_EN
        bypass    = keep && (count == '0) && !redirect;
`else
        bypass    = 1'b0;
`endif
        dec_valid = (count != '0) && !redirect;
        dec_instr = q_instr[rd_ptr];
        dec_pc    = q_pc[rd_ptr];
        if (bypass) begin
            dec_valid = 1'b1;
            dec_instr = imem_rdata;
            dec_pc    = resp_pc;
        end
        dec_pc_plus4 = dec_pc + XLEN'(4);
        handshake    = dec_valid && dec_ready;
        // A bypassed word taken by decode never enters the queue, and the
        // empty queue has nothing to pop in that cycle.
        push = keep && !redirect && !(bypass && dec_ready);
        pop  = handshake && !bypass;
    end

    // Fetch/response PCs, credit counters and queue storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect) begin
            // Every request still in flight after this cycle's return is stale.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(ret);
            discard     <= outstanding - CW'(ret);
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + CW'(imem_req) - CW'(ret);
            if (ret && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (keep) begin
                resp_pc <= resp_pc + XLEN'(4);
            end
            if (push) begin
                q_instr[wr_ptr] <= imem_rdata;
                q_pc[wr_ptr]    <= resp_pc;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule
